// File: rtl/simp_alu_pkg.sv
// Shared opcode/state encodings and widths for the SIMP arithmetic unit.
package simp_alu_pkg;

  localparam int W         = 8;
  localparam int MUL_STEPS = W;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_ASR = 4'd10,
    OP_MUL = 4'd11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/arith_seq_unit_mul_seq.sv
// Iterative shift-add 8x8 unsigned multiplier; one step per i_step cycle.
// o_lo/o_hi present the post-step product so the caller can capture it on the last step edge.
module mul_seq
  import simp_alu_pkg::*;
(
  input  logic         ck,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_step,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_last,
  output logic [W-1:0] o_lo,
  output logic [W-1:0] o_hi
);

  localparam int CW = $clog2(MUL_STEPS);

  logic [W-1:0]  r_mcand;
  logic [W-1:0]  r_mplier;
  logic [W-1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_sum;
  logic [W-1:0]  w_acc_next;
  logic [W-1:0]  w_mplier_next;

  // Add multiplicand into the high half when the multiplier LSB is set, then shift the
  // {acc, multiplier} pair right by one; the multiplier register fills with product low bits.
  assign w_sum         = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : {(W+1){1'b0}});
  assign w_acc_next    = w_sum[W:1];
  assign w_mplier_next = {w_sum[0], r_mplier[W-1:1]};

  assign o_last = (r_cnt == CW'(MUL_STEPS - 1));
  assign o_lo   = w_mplier_next;
  assign o_hi   = w_acc_next;

  always_ff @(posedge ck) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_step) begin
      r_mplier <= w_mplier_next;
      r_acc    <= w_acc_next;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/arith_seq_unit.sv
// SIMP 8-bit ALU: single-cycle ops plus optional 8-step MUL (built when SIMP_MUL_EN is defined).
// Without SIMP_MUL_EN, op 11 is treated as reserved and busy/AU_hi stay 0.
module arith_seq_unit
  import simp_alu_pkg::*;
(
  input  logic         ck,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] AU_out,
  output logic [W-1:0] AU_hi,
  output logic         C,
  output logic         O,
  output logic         busy,
  output logic         done
);

  logic [W-1:0] r_au_out;
  logic [W-1:0] r_au_hi;
  logic         r_c;
  logic         r_o;
  logic         r_done;

  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_o;
  logic [W:0]   w_sum;
  logic         w_load_alu;
  logic         w_load_mul;
  logic [W-1:0] w_mul_lo;
  logic [W-1:0] w_mul_hi;

  always_comb begin
    w_res = a;
    w_c   = 1'b0;
    w_o   = 1'b0;
    w_sum = '0;
    case (op_e'(op))
      OP_ADD, OP_ADC: begin
        w_sum = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin & (op == OP_ADC)};
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_o   = (a[W-1] == b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      // Bit W of the 9-bit difference is the borrow out.
      OP_SUB, OP_SBC: begin
        w_sum = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin & (op == OP_SBC)};
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_o   = (a[W-1] != b[W-1]) && (w_sum[W-1] != a[W-1]);
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_NOT: w_res = ~a;
      OP_SHL: begin
        w_res = {a[W-2:0], 1'b0};
        w_c   = a[W-1];
        w_o   = a[W-1] ^ a[W-2];
      end
      OP_SHR: begin
        w_res = {1'b0, a[W-1:1]};
        w_c   = a[0];
      end
      OP_ASR: begin
        w_res = {a[W-1], a[W-1:1]};
        w_c   = a[0];
      end
      default: ;
    endcase
  end

`ifdef SIMP_MUL_EN
  state_e r_state;
  state_e w_state_next;
  logic   w_mul_load;
  logic   w_mul_last;

  always_ff @(posedge ck) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // start is only honoured in IDLE, so requests during a multiply are dropped.
  always_comb begin
    w_state_next = r_state;
    w_mul_load   = 1'b0;
    w_load_alu   = 1'b0;
    w_load_mul   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            w_mul_load   = 1'b1;
            w_state_next = ST_MUL;
          end else begin
            w_load_alu = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_last) begin
          w_load_mul   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  mul_seq u_mul_seq (
    .ck     (ck),
    .rst    (rst),
    .i_load (w_mul_load),
    .i_step (r_state == ST_MUL),
    .i_a    (a),
    .i_b    (b),
    .o_last (w_mul_last),
    .o_lo   (w_mul_lo),
    .o_hi   (w_mul_hi)
  );

  assign busy = (r_state == ST_MUL);
`else
  assign w_load_alu = start;
  assign w_load_mul = 1'b0;
  assign w_mul_lo   = '0;
  assign w_mul_hi   = '0;
  assign busy       = 1'b0;
`endif

  always_ff @(posedge ck) begin
    if (rst) begin
      r_au_out <= '0;
      r_au_hi  <= '0;
      r_c      <= 1'b0;
      r_o      <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_load_alu | w_load_mul;
      if (w_load_alu) begin
        r_au_out <= w_res;
        r_au_hi  <= '0;
        r_c      <= w_c;
        r_o      <= w_o;
      end else if (w_load_mul) begin
        r_au_out <= w_mul_lo;
        r_au_hi  <= w_mul_hi;
        r_c      <= |w_mul_hi;
        r_o      <= 1'b0;
      end
    end
  end

  assign AU_out = r_au_out;
  assign AU_hi  = r_au_hi;
  assign C      = r_c;
  assign O      = r_o;
  assign done   = r_done;

endmodule

// File: tb/tb_arith_seq_unit.sv
// Directed plus random checks of arith_seq_unit against an arithmetic reference model.
module tb_arith_seq_unit;

  logic       ck = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] op = 4'd0;
  logic [7:0] a = 8'd0;
  logic [7:0] b = 8'd0;
  logic       cin = 1'b0;
  logic [7:0] AU_out;
  logic [7:0] AU_hi;
  logic       C;
  logic       O;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] hi;
    logic       c;
    logic       o;
    int         nbusy;
  } res_t;

  arith_seq_unit dut (
    .ck     (ck),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .AU_out (AU_out),
    .AU_hi  (AU_hi),
    .C      (C),
    .O      (O),
    .busy   (busy),
    .done   (done)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; overflow means the signed result leaves [-128,127].
  function automatic res_t model(input int mop, input int ma, input int mb, input int mc);
    res_t r;
    int s;
    int sa;
    int sb;
    int ss;
    sa = (ma > 127) ? ma - 256 : ma;
    sb = (mb > 127) ? mb - 256 : mb;
    r.out = ma[7:0];
    r.hi = 8'd0;
    r.c = 1'b0;
    r.o = 1'b0;
    r.nbusy = 0;
    case (mop)
      0, 1: begin
        s  = ma + mb + ((mop == 1) ? mc : 0);
        ss = sa + sb + ((mop == 1) ? mc : 0);
        r.out = s[7:0];
        r.c = (s > 255);
        r.o = (ss > 127) || (ss < -128);
      end
      2, 3: begin
        s  = ma - mb - ((mop == 3) ? mc : 0);
        ss = sa - sb - ((mop == 3) ? mc : 0);
        r.out = s[7:0];
        r.c = (s < 0);
        r.o = (ss > 127) || (ss < -128);
      end
      4: begin s = ma & mb; r.out = s[7:0]; end
      5: begin s = ma | mb; r.out = s[7:0]; end
      6: begin s = ma ^ mb; r.out = s[7:0]; end
      7: begin s = ~ma; r.out = s[7:0]; end
      8: begin
        s  = ma * 2;
        ss = sa * 2;
        r.out = s[7:0];
        r.c = (ma > 127);
        r.o = (ss > 127) || (ss < -128);
      end
      9: begin
        s = ma / 2;
        r.out = s[7:0];
        r.c = (ma % 2 == 1);
      end
      10: begin
        ss = sa >>> 1;
        r.out = ss[7:0];
        r.c = (ma % 2 == 1);
      end
`ifdef SIMP_MUL_EN
      11: begin
        s = ma * mb;
        r.out = s[7:0];
        r.hi = s[15:8];
        r.c = (s > 255);
        r.nbusy = 8;
      end
`endif
      default: ;
    endcase
    return r;
  endfunction

  task automatic run(input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                     input logic t_cin, input bit intrude);
    res_t m;
    int   n;
    int   nbusy;
    bit   seen;
    m = model(int'(t_op), int'(t_a), int'(t_b), int'(t_cin));
    @(negedge ck);
    start = 1'b1; op = t_op; a = t_a; b = t_b; cin = t_cin;
    seen = 1'b0; nbusy = 0; n = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge ck);
      n = k;
      if (intrude && (k == 2 || k == 3)) begin
        start = 1'b1; op = 4'd0; a = 8'h33; b = 8'h44;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) nbusy++;
    end
    $display("txn op=%0d a=%02h b=%02h cin=%0d -> out=%02h hi=%02h C=%0d O=%0d cycles=%0d",
             t_op, t_a, t_b, t_cin, AU_out, AU_hi, C, O, n);
    check("done_seen", 16'(seen), 16'd1);
    check("done_cycle", 16'(n), 16'(m.nbusy + 1));
    check("busy_cycles", 16'(nbusy), 16'(m.nbusy));
    check("au_out", 16'(AU_out), 16'(m.out));
    check("au_hi", 16'(AU_hi), 16'(m.hi));
    check("carry", 16'(C), 16'(m.c));
    check("ovf", 16'(O), 16'(m.o));
    check("busy_at_done", 16'(busy), 16'd0);
    for (int j = 1; j <= 2; j++) begin
      @(negedge ck);
      check("done_pulse", 16'(done), 16'd0);
      check("hold_out", 16'(AU_out), 16'(m.out));
      check("hold_hi", 16'(AU_hi), 16'(m.hi));
    end
  endtask

  initial begin
    repeat (3) @(negedge ck);
    check("rst_out", 16'(AU_out), 16'd0);
    check("rst_hi", 16'(AU_hi), 16'd0);
    check("rst_c", 16'(C), 16'd0);
    check("rst_o", 16'(O), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    rst = 1'b0;

    run(4'd0, 8'h7F, 8'h01, 1'b0, 1'b0);
    check("add_ovf_out", 16'(AU_out), 16'h80);
    check("add_ovf_o", 16'(O), 16'd1);
    run(4'd2, 8'h00, 8'h01, 1'b0, 1'b0);
    check("sub_borrow", 16'(C), 16'd1);
    run(4'd3, 8'h05, 8'h02, 1'b1, 1'b0);
    check("sbc_out", 16'(AU_out), 16'h02);
    run(4'd1, 8'hFF, 8'h00, 1'b1, 1'b0);
    run(4'd8, 8'hC0, 8'h00, 1'b0, 1'b0);
    run(4'd10, 8'h81, 8'h00, 1'b0, 1'b0);
    check("asr_out", 16'(AU_out), 16'hC0);
    run(4'd9, 8'h81, 8'h00, 1'b0, 1'b0);
    run(4'd14, 8'h5A, 8'h12, 1'b1, 1'b0);
    check("rsv_out", 16'(AU_out), 16'h5A);

`ifdef SIMP_MUL_EN
    run(4'd11, 8'h10, 8'h10, 1'b0, 1'b1);
    check("mul_hi", 16'(AU_hi), 16'h01);

    // Abort a multiply with reset on its fourth busy cycle.
    @(negedge ck);
    start = 1'b1; op = 4'd11; a = 8'hFF; b = 8'hFF; cin = 1'b0;
    @(negedge ck);
    start = 1'b0;
    repeat (3) @(negedge ck);
    check("busy_before_rst", 16'(busy), 16'd1);
    rst = 1'b1;
    @(negedge ck);
    check("abort_out", 16'(AU_out), 16'd0);
    check("abort_hi", 16'(AU_hi), 16'd0);
    check("abort_c", 16'(C), 16'd0);
    check("abort_o", 16'(O), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_done", 16'(done), 16'd0);
    rst = 1'b0;
    repeat (10) begin
      @(negedge ck);
      check("abort_no_done", 16'(done), 16'd0);
    end
`else
    run(4'd11, 8'h5A, 8'h77, 1'b0, 1'b0);
    check("op11_rsv_out", 16'(AU_out), 16'h5A);
`endif

    run(4'd0, 8'h01, 8'h01, 1'b0, 1'b0);
    check("add_after", 16'(AU_out), 16'h02);

    for (int i = 0; i < 150; i++) begin
      run(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 1)), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
